// File: rtl/cordic_prerotate.sv
// rtl/cordic_prerotate.sv - quadrant pre-rotation and credit flow control ahead of a fixed-latency CORDIC pipeline
module cordic_prerotate #(
    parameter int LATENCY   = 17,
    parameter int CREDITS   = 8,
    parameter int PI_Q      = 3217,
    parameter int HALF_PI_Q = 1608
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [31:0] in_x,
    input  logic signed [31:0] in_y,
    input  logic signed [31:0] in_z,
    output logic signed [31:0] x0,
    output logic signed [31:0] y0,
    output logic signed [31:0] z0,
    output logic               out_valid,
    output logic               in_err,
    output logic               res_valid,
    input  logic               res_pop
);

    localparam int                CW       = $clog2(CREDITS + 1);
    localparam logic [CW-1:0]     CRED_MAX = CW'(CREDITS);
    localparam logic signed [31:0] PI_S    = 32'(PI_Q);
    localparam logic signed [31:0] NPI_S   = 32'(-PI_Q);
    localparam logic signed [31:0] HALF_S  = 32'(HALF_PI_Q);
    localparam logic signed [31:0] NHALF_S = 32'(-HALF_PI_Q);

    logic [CW-1:0]      credit_q, credit_d;
    logic signed [31:0] x0_q, y0_q, z0_q;
    logic signed [31:0] x0_d, y0_d, z0_d;
    logic               out_valid_q, out_valid_d;
    logic               in_err_q, in_err_d;
    logic [LATENCY-1:0] dly_q;

    logic xfer;
    logic pop_ok;
    logic z_out_of_range;
    logic z_above;
    logic z_below;

    // Ready is held low during reset so nothing is accepted into a line being cleared.
    assign in_ready = (credit_q != '0) && rst_n;
    assign xfer     = in_valid && in_ready;
    // A pop at full credit has nothing to return.
    assign pop_ok   = res_pop && (credit_q != CRED_MAX);

    assign z_out_of_range = (in_z >= PI_S) || (in_z < NPI_S);
    assign z_above        = in_z > HALF_S;
    assign z_below        = in_z < NHALF_S;

    assign x0        = x0_q;
    assign y0        = y0_q;
    assign z0        = z0_q;
    assign out_valid = out_valid_q;
    assign in_err    = in_err_q;
    assign res_valid = dly_q[LATENCY-1];

    // Credit bookkeeping: a simultaneous take and return cancel out.
    always_comb begin
        credit_d = credit_q;
        if (xfer && !res_pop) begin
            credit_d = credit_q - 1'b1;
        end else if (!xfer && pop_ok) begin
            credit_d = credit_q + 1'b1;
        end
    end

    // Fold the angle into [-pi/2, pi/2] by rotating the vector half a turn; bad angles pass with z=0.
    always_comb begin
        x0_d        = x0_q;
        y0_d        = y0_q;
        z0_d        = z0_q;
        out_valid_d = 1'b0;
        in_err_d    = 1'b0;
        if (xfer) begin
            out_valid_d = 1'b1;
            if (z_out_of_range) begin
                in_err_d = 1'b1;
                x0_d     = in_x;
                y0_d     = in_y;
                z0_d     = '0;
            end else if (z_above) begin
                x0_d = -in_x;
                y0_d = -in_y;
                z0_d = in_z - PI_S;
            end else if (z_below) begin
                x0_d = -in_x;
                y0_d = -in_y;
                z0_d = in_z + PI_S;
            end else begin
                x0_d = in_x;
                y0_d = in_y;
                z0_d = in_z;
            end
        end
    end

    // Operand and credit registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credit_q    <= CRED_MAX;
            x0_q        <= '0;
            y0_q        <= '0;
            z0_q        <= '0;
            out_valid_q <= 1'b0;
            in_err_q    <= 1'b0;
        end else begin
            credit_q    <= credit_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            z0_q        <= z0_d;
            out_valid_q <= out_valid_d;
            in_err_q    <= in_err_d;
        end
    end

    // Valid delay line matching the CORDIC depth; clearing it drops in-flight results on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dly_q <= '0;
        end else begin
            dly_q[0] <= out_valid_q;
            for (int i = 1; i < LATENCY; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_cordic_prerotate.sv
// tb/tb_cordic_prerotate.sv - scoreboard bench for cordic_prerotate
module tb_cordic_prerotate;

    localparam int LATENCY = 17;
    localparam int CREDITS = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [31:0] in_x = '0;
    logic signed [31:0] in_y = '0;
    logic signed [31:0] in_z = '0;
    logic signed [31:0] x0, y0, z0;
    logic               out_valid, in_err, res_valid;
    logic               res_pop = 1'b0;

    cordic_prerotate #(
        .LATENCY(LATENCY), .CREDITS(CREDITS), .PI_Q(3217), .HALF_PI_Q(1608)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_z(in_z),
        .x0(x0), .y0(y0), .z0(z0),
        .out_valid(out_valid), .in_err(in_err), .res_valid(res_valid),
        .res_pop(res_pop)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit rst;
        int x;
        int y;
        int z;
        bit err;
    } exp_t;

    exp_t expq[$];
    int   resq[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   model_cred = CREDITS;
    int   ov_seen = 0;
    bit   mon_en = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares DUT outputs to the scoreboard once per cycle, away from the edge.
    initial begin
        exp_t e;
        int   lx, ly, lz;
        bit   exp_ov, exp_err, exp_res;
        lx = 0; ly = 0; lz = 0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (mon_en) begin
                exp_ov  = 0;
                exp_err = 0;
                if (expq.size() > 0 && expq[0].cyc == cyc) begin
                    e = expq.pop_front();
                    if (e.rst) begin
                        lx = 0; ly = 0; lz = 0;
                    end else begin
                        exp_ov = 1; exp_err = e.err;
                        lx = e.x; ly = e.y; lz = e.z;
                    end
                end
                if (out_valid === 1'b1) ov_seen++;
                chk("out_valid", int'(out_valid), int'(exp_ov));
                chk("in_err", int'(in_err), int'(exp_err));
                chk("x0", x0, lx);
                chk("y0", y0, ly);
                chk("z0", z0, lz);
                exp_res = (resq.size() > 0 && resq[0] == cyc);
                if (exp_res) void'(resq.pop_front());
                if (exp_res || res_valid !== 1'b0)
                    chk("res_valid", int'(res_valid), int'(exp_res));
            end
        end
    end

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            rst_n    = 1'b0;
            in_valid = 1'b0;
            res_pop  = 1'b0;
            resq.delete();
            expq.push_back('{cyc + 1, 1'b1, 0, 0, 0, 1'b0});
            model_cred = CREDITS;
            mon_en = 1;
            #1;
            chk("in_ready_in_reset", int'(in_ready), 0);
            @(negedge clk);
        end
    endtask

    task automatic step(input bit v, input int x, input int y, input int z, input bit pop,
                        input int ex, input int ey, input int ez, input bit eerr);
        bit xf;
        rst_n    = 1'b1;
        in_valid = v;
        in_x     = x;
        in_y     = y;
        in_z     = z;
        res_pop  = pop;
        #1;
        chk("in_ready", int'(in_ready), int'(model_cred != 0));
        xf = v && (model_cred != 0);
        if (xf) begin
            expq.push_back('{cyc + 1, 1'b0, ex, ey, ez, eerr});
            resq.push_back(cyc + 1 + LATENCY);
        end
        if (xf && !pop) model_cred--;
        else if (!xf && pop && model_cred < CREDITS) model_cred++;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit pop);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, pop, 0, 0, 0, 0);
    endtask

    task automatic stream(input int n, input int base);
        for (int i = 0; i < n; i++)
            step(1, base + i * 10, -i, i * 100, 0, base + i * 10, -i, i * 100, 0);
    endtask

    initial begin
        int snap;
        @(negedge clk);
        do_reset(2);

        // Pass-through with result 17 cycles later.
        step(1, 1000, 0, 804, 0, 1000, 0, 804, 0);
        idle(20, 1);

        // Upper and lower half-plane folding.
        step(1, 1000, 200, 2500, 0, -1000, -200, -717, 0);
        step(1, 1000, 200, -2500, 0, -1000, -200, 717, 0);
        idle(20, 1);

        // Boundaries around pi/2 and pi.
        step(1, 300, -50, 1608, 0, 300, -50, 1608, 0);
        step(1, 300, -50, 1609, 0, -300, 50, -1608, 0);
        step(1, 300, -50, 4000, 0, 300, -50, 0, 1);
        step(1, 300, -50, 3217, 0, 300, -50, 0, 1);
        step(1, 300, -50, -3217, 0, -300, 50, 0, 0);
        step(1, 300, -50, -1608, 0, 300, -50, -1608, 0);
        step(1, 300, -50, -1609, 0, -300, 50, 1608, 0);
        idle(25, 1);

        // Credit exhaustion: 10 offered, 8 taken.
        snap = ov_seen;
        stream(10, 50);
        idle(1, 0);
        chk("stream_accepted", ov_seen - snap, 8);
        // Pop together with valid at zero credit: transfer only on the following cycle.
        snap = ov_seen;
        step(1, 7, 7, 7, 1, 7, 7, 7, 0);
        step(1, 7, 7, 7, 0, 7, 7, 7, 0);
        idle(1, 0);
        chk("pop_then_accept", ov_seen - snap, 1);
        idle(30, 1);

        // Pop and transfer together at full credit keep the count at CREDITS.
        step(1, 11, 12, 13, 1, 11, 12, 13, 0);
        idle(1, 0);
        snap = ov_seen;
        stream(9, 500);
        idle(1, 0);
        chk("full_pop_xfer_accepted", ov_seen - snap, 8);
        idle(30, 1);

        // Reset mid-flight discards pending results and restores credits.
        stream(3, 900);
        idle(5, 0);
        do_reset(1);
        idle(25, 0);
        snap = ov_seen;
        stream(9, 700);
        idle(1, 0);
        chk("post_reset_accepted", ov_seen - snap, 8);
        idle(30, 1);

        chk("expq_drained", expq.size(), 0);
        chk("resq_drained", resq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_prerotate.md
CORDIC_PREROTATE -- requirements
Module: cordic_prerotate

Interface
REQ-001 The module SHALL have parameter LATENCY, default 17, meaning the number of cycles from a registered x0/y0/z0 change to the matching CORDIC x/y output.
REQ-002 The module SHALL have parameter CREDITS, default 8, meaning the number of free downstream result-FIFO entries (1..255).
REQ-003 The module SHALL have parameter PI_Q, default 3217, meaning pi in rad*1024 fixed point.
REQ-004 The module SHALL have parameter HALF_PI_Q, default 1608, meaning pi/2 in rad*1024 fixed point.
REQ-005 The module SHALL use one clock and a synchronous, active-low reset.
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 The module SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-008 The module SHALL have ports in_valid (input, 1) and in_ready (output, 1): the request handshake.
REQ-009 The module SHALL have ports in_x, in_y (input, 32 each): signed start vector.
REQ-010 The module SHALL have port in_z (input, 32): signed angle in rad*1024.
REQ-011 The module SHALL have ports x0, y0, z0 (output reg, 32 each): registered operands to the CORDIC pipeline.
REQ-012 The module SHALL have port out_valid (output reg, 1): x0/y0/z0 hold a new operand this cycle.
REQ-013 The module SHALL have port in_err (output reg, 1): the current operand had an out-of-range angle.
REQ-014 The module SHALL have port res_valid (output reg, 1): CORDIC x/y hold the result of an accepted operand this cycle.
REQ-015 The module SHALL have port res_pop (input, 1): a downstream FIFO entry was freed; returns one credit.

Function
REQ-016 A transfer SHALL occur when in_valid=1 and in_ready=1 on a rising clk edge.
REQ-017 in_ready SHALL be combinational, equal to (credit_cnt != 0) && rst_n.
REQ-018 On a transfer with in_z > HALF_PI_Q, the module SHALL register x0=-in_x, y0=-in_y, z0=in_z-PI_Q (two's complement, 32-bit wrap).
REQ-019 On a transfer with in_z < -HALF_PI_Q, the module SHALL register x0=-in_x, y0=-in_y, z0=in_z+PI_Q.
REQ-020 On a transfer with -HALF_PI_Q <= in_z <= HALF_PI_Q, the module SHALL register x0=in_x, y0=in_y, z0=in_z unchanged.
REQ-021 On a transfer with in_z >= PI_Q or in_z < -PI_Q, the module SHALL set in_err=1, register x0=in_x, y0=in_y, z0=0, and still count the operand.
REQ-022 out_valid and in_err SHALL be 1 for exactly the cycle after a transfer and 0 otherwise; x0/y0/z0 SHALL hold their value when no transfer occurs.
REQ-023 Latency in->x0/y0/z0 SHALL be 1 cycle; full throughput SHALL be one transfer per cycle while credits remain.
REQ-024 A LATENCY-deep shift register of out_valid SHALL drive res_valid, asserting res_valid exactly LATENCY cycles after the out_valid pulse.
REQ-025 credit_cnt (width clog2(CREDITS+1)) SHALL decrement on a transfer, increment on res_pop, and be unchanged when both occur in the same cycle.
REQ-026 res_pop when credit_cnt==CREDITS SHALL be ignored (no overflow); a transfer SHALL never occur at credit_cnt==0.
REQ-027 The module SHALL require no stall or enable on the CORDIC pipeline; flow control SHALL be solely by credits.

Reset
REQ-028 While rst_n=0 at a clk edge, the module SHALL clear x0=y0=z0=0, out_valid=0, in_err=0, res_valid=0, the whole valid delay line, and set credit_cnt=CREDITS.
REQ-029 A reset mid-operation SHALL discard in-flight operands: no res_valid pulse SHALL appear for operands accepted before reset.
REQ-030 in_ready SHALL be 0 during reset and 1 in the first cycle after rst_n rises.

Verification
REQ-031 The bench SHALL drive in_x=1000, in_y=0, in_z=804 -> next cycle x0=1000, y0=0, z0=804, out_valid=1, and res_valid=1 exactly 17 cycles later.
REQ-032 The bench SHALL drive in_x=1000, in_y=200, in_z=2500 -> x0=-1000, y0=-200, z0=-717; then in_z=-2500 -> z0=717, with negated x0/y0.
REQ-033 The bench SHALL drive in_z=1608 -> pass-through; then in_z=1609 -> z0=-1608, negated; then in_z=4000 -> in_err=1, z0=0.
REQ-034 With CREDITS=8 and res_pop=0, the bench SHALL stream 10 requests -> exactly 8 accepted and in_ready=0 thereafter; one res_pop -> one more accepted.
REQ-035 At credit_cnt=0, the bench SHALL assert res_pop and in_valid together -> the transfer occurs the cycle after the credit returns; at credit_cnt=CREDITS with simultaneous pop and transfer, the count stays unchanged.
REQ-036 The bench SHALL accept 3 operands and assert rst_n=0 for 1 cycle, 5 cycles later -> no res_valid pulses, credit_cnt=8, in_ready=1 after release.
